ifetch32: RTL and testbench
===========================

# ifetch32

Instruction fetch unit that produces the 32-bit instruction stream consumed by the `idec32` decoder. It sits between instruction memory and the decoder, and owns the fetch PC. It issues single-outstanding word requests to instruction memory and buffers one fetched instruction for the decoder. It honours decoder stalls and redirects the PC on a taken branch (`ib`/`bv`), discarding any wrong-path instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_WORD`, 32'hE1A0_0000, word driven on `iout` whenever no valid instruction is held
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  decoder cannot accept `iout` this cycle
- `ib`  in  1  taken branch; redirect fetch to `bv`
- `bv`  in  32  branch target address
- `imem_req`  out  1  memory request valid
- `imem_addr`  out  32  word address of request (= fetch PC)
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may arrive in the same cycle as the request
- `imem_rdata`  in  32  instruction word
- `iout`  out  32  instruction to decoder
- `iout_valid`  out  1  `iout` holds a real instruction
- `pc_out`  out  32  address of the instruction in `iout`

## Operation
- Reset values: state IDLE, fetch PC = `RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `iout`=`NOP_WORD`, `iout_valid`=0, `pc_out`=`RESET_PC`.
- The output buffer is one entry (`iout`, `pc_out`, `iout_valid`). It drains when `iout_valid && !stall`.
- "Room" means `!iout_valid || !stall`.
- FSM states:
  - IDLE: `imem_req`=0; always goes to RUN on the next cycle.
  - RUN: `imem_req` = room && !`ib`.
    - Request with ack: load buffer (`iout`=rdata, `pc_out`=PC, valid=1), PC += 4, stay in RUN.
    - Request without ack: go to BUSY.
  - BUSY: `imem_req`=1, with `imem_addr` held stable until ack.
    - The buffer is empty throughout BUSY.
    - On ack: load buffer, PC += 4, go to RUN.
  - DROP: `imem_req`=1, `imem_addr` held at the stale address until ack.
    - On ack: discard rdata, go to RUN.
- `ib`=1 in any state except IDLE:
  - PC ← `bv`, `iout_valid` ← 0, `iout` ← `NOP_WORD`.
  - In RUN, no request is issued that cycle.
  - In BUSY without ack, go to DROP.
  - In BUSY or RUN with a simultaneous ack, discard rdata and take RUN as the next state.
  - In DROP, PC is overwritten with the newest `bv`.
- `ib` in IDLE is ignored.
- When `iout_valid`=0 and `stall`=1, the empty buffer still accepts a word.
- The fetch PC wraps modulo 2^32 (0xFFFF_FFFC + 4 → 0).
- `bv` is used as given; its low 2 bits are not checked.
- An `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Asynchronous reset forces all reset values immediately. The first request is in the second cycle after `rst_n` rises (IDLE, then RUN).
- Fetch latency: ack in cycle N gives `iout_valid` at edge N+1.
- Zero-wait memory yields one instruction per cycle.
- A request with k wait cycles costs k+1 cycles per instruction.
- Branch: `ib` at edge N leaves `iout_valid`=0 after N.
  - In RUN, the first target request is issued in cycle N+1.
  - In BUSY, the target request is issued in the cycle after the DROP ack.
- A stall does not drop a held word. `iout`/`pc_out` stay stable while `iout_valid && stall`.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_WORD`
  - `PC_STEP` (=4)
  - the fetch state enum (IDLE, RUN, BUSY, DROP), shared with future pipeline control
- No sub-module. The block is a single FSM plus PC and output registers (about 150–200 lines).

## Test plan
- Reset: hold `rst_n` low, release, with `RESET_PC`=0.
  - During reset: all outputs at reset values.
  - `imem_req` rises in the second cycle after release, with `imem_addr`=0.
- Zero-wait memory: ack = req, rdata = addr ^ 0xA5A5_0000.
  - `iout` gives 0xA5A5_0000, 0xA5A5_0004, 0xA5A5_0008 on consecutive cycles.
  - `pc_out` gives 0, 4, 8.
- Stall: `stall`=1 for 3 cycles while `iout` holds the word from 0x8.
  - `iout`/`pc_out` stay stable and `imem_req`=0.
  - Fetch of 0xC starts in the cycle `stall` falls.
- Branch in RUN: `ib`=1, `bv`=0x100.
  - Next cycle: `iout_valid`=0, `iout`=`NOP_WORD`, `imem_addr`=0x100.
  - Next valid `pc_out`=0x100.
- Branch in BUSY: ack delayed 3 cycles on address 0x10, `ib`=1 with `bv`=0x200 in the first wait cycle.
  - `imem_addr` holds 0x10 until ack.
  - The 0x10 data never appears as valid.
  - The next request is to 0x200.
- Mid-operation reset: drop `rst_n` in BUSY.
  - Outputs return to reset values without a clock edge.
  - A late ack after release is ignored and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch constants and the fetch state enum used by pipeline control.
package cpu_pkg;

    localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BUSY,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/ifetch32.sv
// Instruction fetch: single-outstanding memory requests, one-entry output buffer,
// decoder stall handling and branch redirect with wrong-path discard.
module ifetch32
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ib,
    input  logic [31:0] bv,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] iout,
    output logic        iout_valid,
    output logic [31:0] pc_out
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  stale_addr;
    logic         room;

    assign room = !iout_valid || !stall;

    // DROP keeps presenting the abandoned address while pc already holds the target.
    assign imem_addr = (state == DROP) ? stale_addr : pc;

    always_comb begin
        imem_req = 1'b0;
        unique case (state)
            IDLE:       imem_req = 1'b0;
            RUN:        imem_req = room && !ib;
            BUSY, DROP: imem_req = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
            iout       <= NOP_WORD;
            iout_valid <= 1'b0;
            pc_out     <= RESET_PC;
        end else begin
            if (iout_valid && !stall) begin
                iout_valid <= 1'b0;
                iout       <= NOP_WORD;
            end

            unique case (state)
                IDLE: state <= RUN;

                RUN: begin
                    if (ib) begin
                        pc <= bv;
                    end else if (room) begin
                        if (imem_ack) begin
                            iout       <= imem_rdata;
                            pc_out     <= pc;
                            iout_valid <= 1'b1;
                            pc         <= pc + PC_STEP;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (ib) begin
                        pc <= bv;
                        if (imem_ack) begin
                            state <= RUN;
                        end else begin
                            stale_addr <= pc;
                            state      <= DROP;
                        end
                    end else if (imem_ack) begin
                        iout       <= imem_rdata;
                        pc_out     <= pc;
                        iout_valid <= 1'b1;
                        pc         <= pc + PC_STEP;
                        state      <= RUN;
                    end
                end

                DROP: begin
                    if (ib) begin
                        pc <= bv;
                    end
                    if (imem_ack) begin
                        state <= RUN;
                    end
                end
            endcase

            // A taken branch flushes the buffer regardless of what the case above loaded.
            if (ib && state != IDLE) begin
                iout_valid <= 1'b0;
                iout       <= NOP_WORD;
            end
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32: scoreboard of expected instruction words, immediate assertions.
module tb_ifetch32;

    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        ib = 1'b0;
    logic [31:0] bv = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] iout;
    logic        iout_valid;
    logic [31:0] pc_out;

    logic auto_ack = 1'b1;
    logic man_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_word[$];
    logic [31:0] exp_pc[$];

    always #5 clk = ~clk;

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = imem_addr ^ KEY;

    ifetch32 #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .ib         (ib),
        .bv         (bv),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .iout       (iout),
        .iout_valid (iout_valid),
        .pc_out     (pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_word(input logic [31:0] addr);
        exp_word.push_back(addr ^ KEY);
        exp_pc.push_back(addr);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_iout"}, iout, NOP);
        chk({tag, "_valid"}, {31'b0, iout_valid}, 32'd0);
        chk({tag, "_pcout"}, pc_out, 32'h0);
    endtask

    // Advance one edge; a word that was not held over from a stalled cycle is new and is scored.
    task automatic tick();
        logic pv, ps;
        pv = iout_valid;
        ps = stall;
        @(posedge clk);
        #1;
        if (rst_n && iout_valid && (!pv || !ps)) begin
            if (exp_word.size() == 0) begin
                chk("unexpected_word", pc_out, 32'hDEAD_BEEF);
            end else begin
                chk("sb_iout", iout, exp_word.pop_front());
                chk("sb_pcout", pc_out, exp_pc.pop_front());
            end
        end
    endtask

    initial begin
        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_hold");

        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        rst_n = 1'b1;
        #1;
        chk("rel_idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        tick();
        tick();
        chk("hold8_iout", iout, 32'hA5A5_0008);

        // Stall three cycles with the 0x8 word held
        stall = 1'b1;
        #1;
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_iout", iout, 32'hA5A5_0008);
            chk("stall_pcout", pc_out, 32'h8);
            chk("stall_req_hold", {31'b0, imem_req}, 32'd0);
        end
        expect_word(32'hC);
        stall = 1'b0;
        #1;
        chk("unstall_req", {31'b0, imem_req}, 32'd1);
        chk("unstall_addr", imem_addr, 32'hC);
        tick();

        // Branch in RUN
        ib = 1'b1;
        bv = 32'h100;
        #1;
        chk("br_run_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        ib = 1'b0;
        #1;
        chk("br_run_valid", {31'b0, iout_valid}, 32'd0);
        chk("br_run_iout", iout, NOP);
        chk("br_run_addr", imem_addr, 32'h100);
        expect_word(32'h100);
        tick();

        // Move to 0x10 with a slow memory, then branch during the wait
        auto_ack = 1'b0;
        ib = 1'b1;
        bv = 32'h10;
        tick();
        ib = 1'b0;
        #1;
        chk("busy_req_addr", imem_addr, 32'h10);
        tick();
        chk("busy_req", {31'b0, imem_req}, 32'd1);
        chk("busy_addr", imem_addr, 32'h10);
        chk("busy_valid", {31'b0, iout_valid}, 32'd0);
        ib = 1'b1;
        bv = 32'h200;
        tick();
        ib = 1'b0;
        #1;
        chk("drop_addr1", imem_addr, 32'h10);
        chk("drop_req1", {31'b0, imem_req}, 32'd1);
        tick();
        chk("drop_addr2", imem_addr, 32'h10);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        #1;
        chk("drop_discard", {31'b0, iout_valid}, 32'd0);
        chk("target_req", {31'b0, imem_req}, 32'd1);
        chk("target_addr", imem_addr, 32'h200);
        expect_word(32'h200);
        auto_ack = 1'b1;
        tick();

        // Mid-operation asynchronous reset while BUSY
        auto_ack = 1'b0;
        tick();
        chk("pre_rst_addr", imem_addr, 32'h204);
        chk("pre_rst_pcout", pc_out, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        man_ack = 1'b1;
        #1;
        chk("late_ack_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        man_ack = 1'b0;
        auto_ack = 1'b1;
        #1;
        chk("late_ack_ignored", {31'b0, iout_valid}, 32'd0);
        chk("restart_addr", imem_addr, 32'h0);
        expect_word(32'h0);
        tick();

        // PC wrap at the top of the address space
        ib = 1'b1;
        bv = 32'hFFFF_FFFC;
        tick();
        ib = 1'b0;
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0);
        tick();
        tick();
        chk("wrap_addr", imem_addr, 32'h4);

        // Empty buffer accepts a word even while stalled
        ib = 1'b1;
        bv = 32'h40;
        tick();
        ib = 1'b0;
        stall = 1'b1;
        #1;
        chk("empty_stall_req", {31'b0, imem_req}, 32'd1);
        expect_word(32'h40);
        tick();
        chk("empty_stall_valid", {31'b0, iout_valid}, 32'd1);
        auto_ack = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        chk("sb_empty", exp_word.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
